// File: rtl/cordic_fmt_pkg.sv
// Shared number-format constants and state type for the CORDIC float/fixed converters.
package cordic_fmt_pkg;

    localparam int unsigned FIXED_W       = 22;
    localparam int unsigned FRAC_W        = 20;
    localparam int unsigned FLOAT_W       = 32;
    localparam int unsigned EXP_BIAS      = 127;
    // Biased exponent of a Q2.20 value whose magnitude has its MSB set, i.e. [2, 4).
    localparam int unsigned EXP_MAX_FIXED = EXP_BIAS + FIXED_W - 1 - FRAC_W;

    typedef enum logic [1:0] {IDLE, NORM, DONE} f2x_state_t;

    // Two's-complement magnitude; the most negative code maps to itself as an unsigned value.
    function automatic logic [FIXED_W-1:0] fixedAbs(input logic [FIXED_W-1:0] x);
        return x[FIXED_W-1] ? (~x + FIXED_W'(1)) : x;
    endfunction

endpackage

// File: rtl/fixed_to_float_if.sv
// Operand and result handshake bundle between a producer/consumer and fixed_to_float.
interface fixed_to_float_if;
    import cordic_fmt_pkg::*;

    logic [FIXED_W-1:0] fixedPoint;
    logic               in_valid;
    logic               in_ready;
    logic [FLOAT_W-1:0] floatingPoint;
    logic               out_valid;
    logic               out_ready;

    // Master feeds operands and consumes results.
    modport master (
        output fixedPoint, in_valid, out_ready,
        input  in_ready, floatingPoint, out_valid
    );

    // Slave is the converter itself.
    modport slave (
        input  fixedPoint, in_valid, out_ready,
        output in_ready, floatingPoint, out_valid
    );

endinterface

// File: rtl/fixed_to_float.sv
// Q2.20 fixed-point to IEEE-754 single converter, normalising one bit per clock.
module fixed_to_float #(
    parameter int unsigned FIXED_W = cordic_fmt_pkg::FIXED_W,
    parameter int unsigned FRAC_W  = cordic_fmt_pkg::FRAC_W
) (
    input logic              clk,
    input logic              reset_n,
    fixed_to_float_if.slave  bus
);
    import cordic_fmt_pkg::*;

    localparam logic [7:0] ExpInit = 8'(EXP_BIAS + FIXED_W - 1 - FRAC_W);

    f2x_state_t         stateQ, stateD;
    logic [FIXED_W-1:0] magQ, magD;
    logic [7:0]         expQ, expD;
    logic               signQ, signD;
    logic [FLOAT_W-1:0] resultQ, resultD;

    logic               accept;
    logic               opZero;
    logic [FIXED_W-1:0] opAbs;

    assign opAbs  = fixedAbs(bus.fixedPoint);
    assign opZero = (bus.fixedPoint == '0);
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.floatingPoint = resultQ;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state: a result handed off in DONE can be replaced by a new operand the same edge.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE: if (accept) stateD = opZero ? DONE : NORM;
            NORM: if (magQ[FIXED_W-1]) stateD = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    if (accept) stateD = opZero ? DONE : NORM;
                    else        stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Handshake outputs; out_valid comes straight from the state register.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (stateQ)
            IDLE: bus.in_ready = reset_n;
            DONE: begin
                bus.in_ready  = reset_n && bus.out_ready;
                bus.out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next state: load on accept, otherwise shift until the MSB is set.
    always_comb begin
        magD    = magQ;
        expD    = expQ;
        signD   = signQ;
        resultD = resultQ;
        if (accept) begin
            signD = bus.fixedPoint[FIXED_W-1] && !opZero;
            magD  = opAbs;
            expD  = ExpInit;
            if (opZero) resultD = '0;
        end else if (stateQ == NORM) begin
            if (magQ[FIXED_W-1]) begin
                // Leading one is implicit; the 21 remaining bits pad out the 23-bit mantissa.
                resultD = {signQ, expQ, magQ[FIXED_W-2:0], 2'b00};
            end else begin
                magD = magQ << 1;
                expD = expQ - 8'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            magQ    <= '0;
            expQ    <= '0;
            signQ   <= 1'b0;
            resultQ <= '0;
        end else begin
            magQ    <= magD;
            expQ    <= expD;
            signQ   <= signD;
            resultQ <= resultD;
        end
    end

endmodule
